// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit:
// opcode encodings, FSM state encodings, ALU operation codes, PCSrc/RegDst
// select codes and the packed control word produced by the decoder.
package multi_cycle_control_unit_pkg;

  localparam int OP_W_C    = 6;
  localparam int ALUOP_W_C = 3;

  // Opcodes (IR[31:26])
  localparam logic [OP_W_C-1:0] OP_ADD   = 6'b000000;
  localparam logic [OP_W_C-1:0] OP_SUB   = 6'b000001;
  localparam logic [OP_W_C-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OP_W_C-1:0] OP_AND   = 6'b010000;
  localparam logic [OP_W_C-1:0] OP_ANDI  = 6'b010001;
  localparam logic [OP_W_C-1:0] OP_ORI   = 6'b010010;
  localparam logic [OP_W_C-1:0] OP_XORI  = 6'b010011;
  localparam logic [OP_W_C-1:0] OP_SLL   = 6'b011000;
  localparam logic [OP_W_C-1:0] OP_SLTI  = 6'b100110;
  localparam logic [OP_W_C-1:0] OP_SLT   = 6'b100111;
  localparam logic [OP_W_C-1:0] OP_SW    = 6'b110000;
  localparam logic [OP_W_C-1:0] OP_LW    = 6'b110001;
  localparam logic [OP_W_C-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OP_W_C-1:0] OP_BNE   = 6'b110101;
  localparam logic [OP_W_C-1:0] OP_BLTZ  = 6'b110110;
  localparam logic [OP_W_C-1:0] OP_J     = 6'b111000;
  localparam logic [OP_W_C-1:0] OP_JR    = 6'b111001;
  localparam logic [OP_W_C-1:0] OP_JAL   = 6'b111010;
  localparam logic [OP_W_C-1:0] OP_HALT  = 6'b111111;

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_e;

  localparam logic [ALUOP_W_C-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALUOP_W_C-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALUOP_W_C-1:0] ALU_SLL  = 3'b010;
  localparam logic [ALUOP_W_C-1:0] ALU_OR   = 3'b011;
  localparam logic [ALUOP_W_C-1:0] ALU_AND  = 3'b100;
  localparam logic [ALUOP_W_C-1:0] ALU_SLTU = 3'b101;
  localparam logic [ALUOP_W_C-1:0] ALU_SLT  = 3'b110;
  localparam logic [ALUOP_W_C-1:0] ALU_XOR  = 3'b111;

  localparam logic [1:0] PCSRC_PC4    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_RS     = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  localparam logic [1:0] REGDST_RA = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RD = 2'b10;

  typedef struct packed {
    logic                 pc_wre;
    logic                 ir_wre;
    logic                 ins_mem_rw;
    logic                 reg_wre;
    logic                 m_rd;
    logic                 m_wr;
    logic                 alu_src_a;
    logic                 alu_src_b;
    logic                 ext_sel;
    logic                 db_data_src;
    logic                 wr_reg_d_src;
    logic [1:0]           reg_dst;
    logic [1:0]           pc_src;
    logic [ALUOP_W_C-1:0] alu_op;
  } ctrl_t;

  function automatic logic is_branch(input logic [OP_W_C-1:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
  endfunction

  function automatic logic is_jump(input logic [OP_W_C-1:0] op);
    return (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multi_cycle_control_unit_control_decode.sv
// Pure combinational decoder: (reset, state, opcode, Zero, Sign) -> control word.
// Ports:
//   reset_i  forces every enable low, InsMemRW high and all selects to 0
//   state_i  current FSM state
//   op_i     registered opcode
//   zero_i   ALU result == 0
//   sign_i   ALU result[31]
//   ctrl_o   full control word for this cycle
module control_decode
  import multi_cycle_control_unit_pkg::*;
(
  input  logic              reset_i,
  input  state_e            state_i,
  input  logic [OP_W_C-1:0] op_i,
  input  logic              zero_i,
  input  logic              sign_i,
  output ctrl_t             ctrl_o
);

  logic br_taken;

  assign br_taken = ((op_i == OP_BEQ)  &&  zero_i) ||
                    ((op_i == OP_BNE)  && !zero_i) ||
                    ((op_i == OP_BLTZ) &&  sign_i);

  // NOTE: every field gets a default before any branch so no path leaves a
  // field unassigned, which would otherwise infer a latch.
  always_comb begin
    ctrl_o = '0;
    if (reset_i) begin
      ctrl_o.ins_mem_rw = 1'b1;
    end else begin
      // Selects depend on the opcode only, so they stay put for every state
      // of one instruction. Undefined opcodes fall through to the add setup.
      ctrl_o.ext_sel = 1'b1;
      ctrl_o.reg_dst = REGDST_RD;
      ctrl_o.alu_op  = ALU_ADD;
      case (op_i)
        OP_SUB:   ctrl_o.alu_op = ALU_SUB;
        OP_ADDIU: begin
          ctrl_o.alu_src_b = 1'b1;
          ctrl_o.reg_dst   = REGDST_RT;
        end
        OP_AND:   ctrl_o.alu_op = ALU_AND;
        OP_ANDI:  begin
          ctrl_o.alu_op    = ALU_AND;
          ctrl_o.alu_src_b = 1'b1;
          ctrl_o.ext_sel   = 1'b0;
          ctrl_o.reg_dst   = REGDST_RT;
        end
        OP_ORI:   begin
          ctrl_o.alu_op    = ALU_OR;
          ctrl_o.alu_src_b = 1'b1;
          ctrl_o.ext_sel   = 1'b0;
          ctrl_o.reg_dst   = REGDST_RT;
        end
        OP_XORI:  begin
          ctrl_o.alu_op    = ALU_XOR;
          ctrl_o.alu_src_b = 1'b1;
          ctrl_o.ext_sel   = 1'b0;
          ctrl_o.reg_dst   = REGDST_RT;
        end
        OP_SLL:   begin
          ctrl_o.alu_op    = ALU_SLL;
          ctrl_o.alu_src_a = 1'b1;
        end
        OP_SLTI:  begin
          ctrl_o.alu_op    = ALU_SLT;
          ctrl_o.alu_src_b = 1'b1;
          ctrl_o.reg_dst   = REGDST_RT;
        end
        OP_SLT:   ctrl_o.alu_op = ALU_SLT;
        OP_SW:    begin
          ctrl_o.alu_src_b = 1'b1;
          ctrl_o.reg_dst   = REGDST_RA;
        end
        OP_LW:    begin
          ctrl_o.alu_src_b = 1'b1;
          ctrl_o.reg_dst   = REGDST_RT;
        end
        OP_BEQ, OP_BNE, OP_BLTZ: begin
          ctrl_o.alu_op  = ALU_SUB;
          ctrl_o.reg_dst = REGDST_RA;
        end
        OP_JAL:   begin
          ctrl_o.reg_dst      = REGDST_RA;
          ctrl_o.wr_reg_d_src = 1'b1;
        end
        OP_J, OP_JR, OP_HALT: ctrl_o.reg_dst = REGDST_RA;
        default: ;
      endcase

      // Enables and the PC source only act in the cycle that needs them.
      case (state_i)
        S_IF: begin
          ctrl_o.ir_wre     = 1'b1;
          ctrl_o.ins_mem_rw = 1'b1;
        end
        S_ID: begin
          if (is_jump(op_i)) begin
            ctrl_o.pc_wre = 1'b1;
            ctrl_o.pc_src = (op_i == OP_JR) ? PCSRC_RS : PCSRC_JUMP;
          end
          ctrl_o.reg_wre = (op_i == OP_JAL);
        end
        S_EXE_BR: begin
          ctrl_o.pc_wre = 1'b1;
          ctrl_o.pc_src = br_taken ? PCSRC_BRANCH : PCSRC_PC4;
        end
        S_MEM: begin
          ctrl_o.m_wr   = (op_i == OP_SW);
          ctrl_o.m_rd   = (op_i == OP_LW);
          ctrl_o.pc_wre = (op_i == OP_SW);
        end
        S_WB_AL: begin
          ctrl_o.pc_wre  = 1'b1;
          ctrl_o.reg_wre = 1'b1;
        end
        S_WB_LD: begin
          ctrl_o.pc_wre      = 1'b1;
          ctrl_o.reg_wre     = 1'b1;
          ctrl_o.db_data_src = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle MIPS-subset control unit: state register plus next-state logic;
// the control word for the current cycle comes from control_decode.
// Ports:
//   CLK, Reset (async, active-high)   clock and reset
//   op, Zero, Sign                    opcode and ALU flags from the datapath
//   PCWre IRWre InsMemRW RegWre mRD mWR              write/read enables
//   ALUSrcA ALUSrcB ExtSel DBDataSrc WrRegDSrc       1-bit selects
//   RegDst PCSrc ALUOp                               multi-bit selects
//   State                                            current state (debug)
module multi_cycle_control_unit
  import multi_cycle_control_unit_pkg::*;
#(
  parameter int OP_W    = OP_W_C,
  parameter int ALUOP_W = ALUOP_W_C
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    op,
  input  logic               Zero,
  input  logic               Sign,
  output logic               PCWre,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               RegWre,
  output logic               mRD,
  output logic               mWR,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic               DBDataSrc,
  output logic               WrRegDSrc,
  output logic [1:0]         RegDst,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         State
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:     state_d = S_ID;
      S_ID: begin
        if (is_branch(op))                    state_d = S_EXE_BR;
        else if (op == OP_LW || op == OP_SW)  state_d = S_EXE_LS;
        else if (is_jump(op))                 state_d = S_IF;
        else if (op == OP_HALT)               state_d = S_HALT;
        else                                  state_d = S_EXE_AL;
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL:  state_d = S_IF;
      S_EXE_BR: state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (op == OP_LW) ? S_WB_LD : S_IF;
      S_WB_LD:  state_d = S_IF;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;
    endcase
  end

  control_decode u_decode (
    .reset_i (Reset),
    .state_i (state_q),
    .op_i    (op),
    .zero_i  (Zero),
    .sign_i  (Sign),
    .ctrl_o  (ctrl)
  );

  assign PCWre     = ctrl.pc_wre;
  assign IRWre     = ctrl.ir_wre;
  assign InsMemRW  = ctrl.ins_mem_rw;
  assign RegWre    = ctrl.reg_wre;
  assign mRD       = ctrl.m_rd;
  assign mWR       = ctrl.m_wr;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ExtSel    = ctrl.ext_sel;
  assign DBDataSrc = ctrl.db_data_src;
  assign WrRegDSrc = ctrl.wr_reg_d_src;
  assign RegDst    = ctrl.reg_dst;
  assign PCSrc     = ctrl.pc_src;
  assign ALUOp     = ctrl.alu_op;
  assign State     = state_q;

endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
- Moore/Mealy FSM that sequences the multi-cycle MIPS-subset datapath: instruction memory (byte-wide, big-endian, 4 bytes per word), IR, register file, ALU, data memory and PC.
- Decodes the registered opcode, steps through IF/ID/EXE/MEM/WB, and drives every write enable and mux select for the current cycle.
- Sits beside the datapath top; the only datapath inputs it reads are op, Zero and Sign.

Parameters:
- OP_W, 6, opcode width.
- ALUOP_W, 3, ALU operation code width.

Ports:
- CLK  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high; returns the FSM to sIF.
- op  in  6  opcode from IR[31:26].
- Zero  in  1  ALU result == 0.
- Sign  in  1  ALU result[31].
- PCWre  out  1  PC load enable.
- IRWre  out  1  IR load enable.
- InsMemRW  out  1  instruction memory read strobe (1 = read).
- RegWre  out  1  register file write enable.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- ALUSrcA  out  1  0 = rs, 1 = Sa.
- ALUSrcB  out  1  0 = rt, 1 = extended immediate.
- ExtSel  out  1  0 = zero-extend, 1 = sign-extend.
- DBDataSrc  out  1  0 = ALU result, 1 = data memory.
- WrRegDSrc  out  1  0 = DB, 1 = PC+4 (jal).
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd.
- PCSrc  out  2  00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs, 11 = JumpPC.
- ALUOp  out  3  000 add, 001 sub, 010 sll (B<<A), 011 or, 100 and, 101 sltu, 110 slt, 111 xor.
- State  out  4  current state, for debug.

Behaviour:
- Opcodes:
  - add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, xori 010011, sll 011000.
  - slti 100110, slt 100111, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110.
  - j 111000, jr 111001, jal 111010, halt 111111.
- States (4-bit): sIF 0000, sID 0001, sEXE_AL 0110, sEXE_BR 0101, sEXE_LS 0010, sMEM 0011, sWB_AL 0111, sWB_LD 0100, sHALT 1000.
- Transitions:
  - sIF -> sID.
  - sID -> sEXE_BR for beq/bne/bltz; sEXE_LS for lw/sw; sIF for j/jr/jal; sHALT for halt; sEXE_AL otherwise, including undefined opcodes, which are treated as add.
  - sEXE_AL -> sWB_AL -> sIF.
  - sEXE_BR -> sIF.
  - sEXE_LS -> sMEM.
  - sMEM -> sWB_LD for lw; sMEM -> sIF for sw.
  - sWB_LD -> sIF.
  - sHALT -> sHALT until Reset.
- State register updates on the CLK rising edge. Outputs are combinational from state, op, Zero and Sign, so there is zero latency within the cycle.
- Cycles per instruction:

| Class | Cycles |
|---|---|
| ALU | 4 |
| Branch | 3 |
| sw | 4 |
| lw | 5 |
| j/jr/jal | 2 |

- IRWre=1 and InsMemRW=1 only in sIF. InsMemRW=0 elsewhere.
- PCWre=1 only in the last cycle of each instruction: sEXE_BR, sWB_AL, sWB_LD, sMEM (sw only), and sID (jumps only). PCWre=0 in sHALT.
- RegWre=1 only in sWB_AL, sWB_LD, and sID for jal (RegDst=00, WrRegDSrc=1).
- mWR=1 only in sMEM for sw. mRD=1 only in sMEM for lw. DBDataSrc=1 only in sWB_LD.
- PCSrc=01 in sEXE_BR when any of these holds; otherwise 00 in sEXE_BR:
  - beq and Zero=1;
  - bne and Zero=0;
  - bltz and Sign=1.
- In sID: PCSrc=11 for j/jal and 10 for jr.
- ALUOp for branches is sub. ALUSrcA=1 only for sll. ALUSrcB=1 for addiu/andi/ori/xori/slti/lw/sw.
- ExtSel=0 for andi/ori/xori; otherwise 1.
- RegDst=01 for I-type writes; 10 for R-type.
- Every select is held stable across all states of an instruction, so data does not glitch into the WB cycle.
- Reset:
  - While Reset=1, state is forced to sIF asynchronously.
  - All write enables (PCWre, IRWre, RegWre, mWR, mRD) are forced to 0; InsMemRW=1; all selects 0.
  - Reset asserted mid-instruction aborts it without any write. On the first edge after release, IF proceeds.

Decomposition:
- Shared package/include file (cpu_defs): opcode localparams, state encodings, ALUOp codes, PCSrc/RegDst codes.
- One natural sub-module: control_decode (pure combinational op/state -> control word). The top holds only the state register and next-state logic.

Test Plan:
- Reset, release, op=000000 (add) -> states 0,1,6,7,0; PCWre=1 only in the 4th cycle; RegWre=1 with RegDst=10 in cycle 4; ALUOp=000.
- op=110001 (lw) -> 0,1,2,3,4; mRD=1 in cycle 4; RegWre=1, DBDataSrc=1, RegDst=01 in cycle 5; ExtSel=1, ALUSrcB=1.
- op=110100 (beq), Zero=1 -> 3 cycles, PCSrc=01 and PCWre=1 in cycle 3. Repeat with Zero=0 -> PCSrc=00. Repeat as bltz with Sign=1 -> PCSrc=01.
- op=111010 (jal) -> 2 cycles; in cycle 2 PCSrc=11, PCWre=1, RegWre=1, RegDst=00, WrRegDSrc=1.
- op=111111 (halt) -> state 1000 held 20+ cycles with PCWre=IRWre=RegWre=mWR=0. Reset -> State=0000 with no clock edge.
- sw with Reset pulsed asynchronously during sEXE_LS -> mWR never 1; State=0000 immediately; next instruction fetches normally.
